// File: rtl/enoc_switch_allocator.sv
// Per-router switch allocator: one round-robin arbiter per output port with
// wormhole locking; grants are combinational from the registered lock/pointer state.
module enoc_switch_allocator #(
  parameter int N_PORTS = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [0:N_PORTS-1][0:N_PORTS-1]   i_output_req,
  input  logic [0:N_PORTS-1]                i_val,
  input  logic [0:N_PORTS-1]                i_tail,
  input  logic [0:N_PORTS-1]                i_en,
  output logic [0:N_PORTS-1][0:N_PORTS-1]   o_output_grant,
  output logic [0:N_PORTS-1]                o_input_grant
);

  localparam int unsigned W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e       state_q [N_PORTS];
  state_e       state_d [N_PORTS];
  logic [W-1:0] ptr_q   [N_PORTS];
  logic [W-1:0] ptr_d   [N_PORTS];
  logic [W-1:0] owner_q [N_PORTS];
  logic [W-1:0] owner_d [N_PORTS];

  logic [0:N_PORTS-1][0:N_PORTS-1] cand;
  logic [0:N_PORTS-1][0:N_PORTS-1] grant;
  logic                            found;
  int unsigned                     idx;
  int unsigned                     win;

  // cand is indexed [output][input]: the transpose of the request matrix, gated by valid
  always_comb begin
    cand = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        cand[o][i] = i_val[i] & i_output_req[i][o];
      end
    end
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    win   = 0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      state_d[o] = state_q[o];
      ptr_d[o]   = ptr_q[o];
      owner_d[o] = owner_q[o];
      if (!reset && i_en[o]) begin
        if (state_q[o] == LOCKED) begin
          if (cand[o][owner_q[o]]) begin
            grant[o][owner_q[o]] = 1'b1;
            if (i_tail[owner_q[o]]) begin
              state_d[o] = IDLE;
            end
          end
        end else begin
          found = 1'b0;
          win   = 0;
          // Search ptr, ptr+1, ... with an explicit wrap so N_PORTS need not be a power of two
          for (int unsigned k = 0; k < N_PORTS; k++) begin
            idx = int'(ptr_q[o]) + k;
            if (idx >= N_PORTS) begin
              idx = idx - N_PORTS;
            end
            if (!found && cand[o][W'(idx)]) begin
              found = 1'b1;
              win   = idx;
            end
          end
          if (found) begin
            grant[o][W'(win)] = 1'b1;
            ptr_d[o] = (win == N_PORTS - 1) ? '0 : W'(win + 1);
            if (!i_tail[W'(win)]) begin
              state_d[o] = LOCKED;
              owner_d[o] = W'(win);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      if (reset) begin
        state_q[o] <= IDLE;
        ptr_q[o]   <= '0;
        owner_q[o] <= '0;
      end else begin
        state_q[o] <= state_d[o];
        ptr_q[o]   <= ptr_d[o];
        owner_q[o] <= owner_d[o];
      end
    end
  end

  always_comb begin
    o_input_grant = '0;
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        o_input_grant[i] = o_input_grant[i] | grant[o][i];
      end
    end
  end

  assign o_output_grant = grant;

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Scoreboard bench for enoc_switch_allocator: the driver queues hand-computed
// grants per cycle, the monitor pops and compares them on the falling edge.
module tb_enoc_switch_allocator;

  localparam int N = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [0:N-1][0:N-1] i_output_req = '0;
  logic [0:N-1]        i_val = '0;
  logic [0:N-1]        i_tail = '0;
  logic [0:N-1]        i_en = '0;
  logic [0:N-1][0:N-1] o_output_grant;
  logic [0:N-1]        o_input_grant;

  enoc_switch_allocator #(.N_PORTS(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_output_req   (i_output_req),
    .i_val          (i_val),
    .i_tail         (i_tail),
    .i_en           (i_en),
    .o_output_grant (o_output_grant),
    .o_input_grant  (o_input_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:N-1][0:N-1] og;
    logic [0:N-1]        ig;
    string               name;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // rq: nibble per input (MSB nibble = input 0) holding the requested output, F = not valid.
  // ex: nibble per output (MSB nibble = output 0) holding the granted input, F = no grant.
  task automatic drive(input logic rst, input logic [19:0] rq, input logic [0:N-1] tl,
                       input logic [0:N-1] en, input logic [19:0] ex, input string name);
    exp_t       e;
    logic [3:0] nib;
    @(posedge clk);
    #1;
    reset  = rst;
    i_tail = tl;
    i_en   = en;
    e.og   = '0;
    e.ig   = '0;
    e.name = name;
    for (int i = 0; i < N; i++) begin
      nib = rq[19-4*i -: 4];
      i_output_req[i] = '0;
      i_val[i] = (nib != 4'hF);
      if (nib != 4'hF) i_output_req[i][nib] = 1'b1;
    end
    for (int o = 0; o < N; o++) begin
      nib = ex[19-4*o -: 4];
      if (nib != 4'hF) begin
        e.og[o][nib] = 1'b1;
        e.ig[nib]    = 1'b1;
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (i_val[i] && !reset)
          assert ($onehot(i_output_req[i]))
          else $error("protocol violation: input %0d request not one-hot", i);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (o_output_grant === e.og) n_pass++;
        else $display("FAIL %s output_grant got %h want %h", e.name, o_output_grant, e.og);
        n_total++;
        if (o_input_grant === e.ig) n_pass++;
        else $display("FAIL %s input_grant got %b want %b", e.name, o_input_grant, e.ig);
      end
    end
  end

  initial begin
    // Reset with requests present: grants must stay low
    drive(1'b1, 20'hFFFFF, 5'b00000, 5'b11111, 20'hFFFFF, "rst0");
    drive(1'b1, 20'h22222, 5'b11111, 5'b11111, 20'hFFFFF, "rst1");

    // 1: all inputs to e, single-flit, rotate 0..4
    drive(1'b0, 20'h22222, 5'b11111, 5'b11111, 20'hFF0FF, "rr0");
    drive(1'b0, 20'h22222, 5'b11111, 5'b11111, 20'hFF1FF, "rr1");
    drive(1'b0, 20'h22222, 5'b11111, 5'b11111, 20'hFF2FF, "rr2");
    drive(1'b0, 20'h22222, 5'b11111, 5'b11111, 20'hFF3FF, "rr3");
    drive(1'b0, 20'h22222, 5'b11111, 5'b11111, 20'hFF4FF, "rr4");
    drive(1'b0, 20'hFFFFF, 5'b00000, 5'b11111, 20'hFFFFF, "idle1");

    // 2: n sends 3 flits to s, w joins and waits for the tail
    drive(1'b0, 20'hF3FFF, 5'b00000, 5'b11111, 20'hFFF1F, "lock_h");
    drive(1'b0, 20'hF3FF3, 5'b00000, 5'b11111, 20'hFFF1F, "lock_b");
    drive(1'b0, 20'hF3FF3, 5'b01000, 5'b11111, 20'hFFF1F, "lock_t");
    drive(1'b0, 20'hFFFF3, 5'b00001, 5'b11111, 20'hFFF4F, "after_lock");

    // 3: bubble while locked keeps w blocked
    drive(1'b0, 20'hF3FFF, 5'b00000, 5'b11111, 20'hFFF1F, "bub_h");
    drive(1'b0, 20'hFFFF3, 5'b00000, 5'b11111, 20'hFFFFF, "bub_gap0");
    drive(1'b0, 20'hFFFF3, 5'b00000, 5'b11111, 20'hFFFFF, "bub_gap1");
    drive(1'b0, 20'hF3FF3, 5'b01000, 5'b11111, 20'hFFF1F, "bub_t");
    drive(1'b0, 20'hFFFF3, 5'b00001, 5'b11111, 20'hFFF4F, "bub_w");

    // 4: move ptr[e] to 3, then stall e for 4 cycles with requesters 1 and 4
    drive(1'b0, 20'hFF2FF, 5'b00100, 5'b11111, 20'hFF2FF, "en_prep");
    for (int k = 0; k < 4; k++)
      drive(1'b0, 20'hF2FF2, 5'b01001, 5'b11011, 20'hFFFFF, "en_stall");
    drive(1'b0, 20'hF2FF2, 5'b01001, 5'b11111, 20'hFF4FF, "en_rise");
    drive(1'b0, 20'hF2FF2, 5'b01001, 5'b11111, 20'hFF1FF, "en_next");
    drive(1'b0, 20'hFFFFF, 5'b00000, 5'b11111, 20'hFFFFF, "idle4");

    // 5: permutation, every input granted at once
    drive(1'b0, 20'h12340, 5'b11111, 5'b11111, 20'h40123, "perm");

    // 6: reset mid-packet drops the lock and the pointer
    drive(1'b0, 20'hF3FFF, 5'b00000, 5'b11111, 20'hFFF1F, "rp_h");
    drive(1'b0, 20'hF3FFF, 5'b00000, 5'b11111, 20'hFFF1F, "rp_b");
    drive(1'b1, 20'hF3FFF, 5'b00000, 5'b11111, 20'hFFFFF, "rp_rst");
    drive(1'b0, 20'hFFFF3, 5'b00001, 5'b11111, 20'hFFF4F, "rp_w");
    drive(1'b0, 20'hFFF3F, 5'b00010, 5'b11111, 20'hFFF3F, "rp_ptr4");
    drive(1'b1, 20'hFFFFF, 5'b00000, 5'b11111, 20'hFFFFF, "rp_rst2");
    drive(1'b0, 20'hFF3F3, 5'b00101, 5'b11111, 20'hFFF2F, "rp_ptr0");
    drive(1'b0, 20'hFFFFF, 5'b00000, 5'b11111, 20'hFFFFF, "idle6");

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
